io_ready_predicate: RTL and testbench

- Downstream stage of the three I/O check units: A-read, B-read and D-write.
- Combines their masked Empty/Full bits into a single per-instruction IO_ready predicate.
- Decodes the port-relative read/write strobes that are sent to the I/O ports.
- Keeps a per-thread saturating count of consecutive I/O-annulled issues, for livelock/performance observation.

---
 rtl/io_ready_predicate.sv | 195 +++++++++++++++++++
 tb/tb_io_ready_predicate.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_ready_predicate.sv
// Combines the A/B/D I/O check results into one IO_ready predicate and decodes the port strobes.
// It also keeps a saturating per-thread count of consecutive I/O-annulled issues.
module io_ready_predicate #(
    parameter int ADDR_WIDTH           = 10,
    parameter int READ_PORT_COUNT      = 8,
    parameter int READ_PORT_BASE_ADDR  = 0,
    parameter int WRITE_PORT_COUNT     = 8,
    parameter int WRITE_PORT_BASE_ADDR = 0,
    parameter int THREAD_COUNT         = 8,
    parameter int THREAD_ID_WIDTH      = 3,
    parameter int COUNT_WIDTH          = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [THREAD_ID_WIDTH-1:0]  thread_id,
    input  logic [ADDR_WIDTH-1:0]       read_addr_A,
    input  logic [ADDR_WIDTH-1:0]       read_addr_B,
    input  logic [ADDR_WIDTH-1:0]       write_addr_D,
    input  logic                        A_EF_masked,
    input  logic                        A_addr_is_IO,
    input  logic                        B_EF_masked,
    input  logic                        B_addr_is_IO,
    input  logic                        D_EF_masked,
    input  logic                        D_addr_is_IO,
    output logic                        IO_ready,
    output logic [READ_PORT_COUNT-1:0]  A_rden,
    output logic [READ_PORT_COUNT-1:0]  B_rden,
    output logic [WRITE_PORT_COUNT-1:0] D_wren,
    output logic [THREAD_ID_WIDTH-1:0]  thread_out,
    output logic [COUNT_WIDTH-1:0]      stall_count,
    output logic                        stall_saturated
);

    localparam int RD_IDX_W = (READ_PORT_COUNT > 1) ? $clog2(READ_PORT_COUNT) : 1;
    localparam int WR_IDX_W = (WRITE_PORT_COUNT > 1) ? $clog2(WRITE_PORT_COUNT) : 1;
    localparam logic [ADDR_WIDTH-1:0] RD_BASE = ADDR_WIDTH'(READ_PORT_BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] WR_BASE = ADDR_WIDTH'(WRITE_PORT_BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] RD_MASK = ADDR_WIDTH'((1 << RD_IDX_W) - 1);
    localparam logic [ADDR_WIDTH-1:0] WR_MASK = ADDR_WIDTH'((1 << WR_IDX_W) - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    // Only the low index bits of the port offset select the strobe; indices past the
    // port count (non power-of-two counts) simply produce no strobe.
    function automatic logic [READ_PORT_COUNT-1:0] read_onehot(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = (addr - RD_BASE) & RD_MASK;
        return READ_PORT_COUNT'(1) << offset;
    endfunction

    function automatic logic [WRITE_PORT_COUNT-1:0] write_onehot(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = (addr - WR_BASE) & WR_MASK;
        return WRITE_PORT_COUNT'(1) << offset;
    endfunction

    // Stage 1 registers
    logic                       enable_s1_q, enable_s1_d;
    logic [THREAD_ID_WIDTH-1:0] thread_id_s1_q, thread_id_s1_d;
    logic [ADDR_WIDTH-1:0]      read_addr_A_s1_q, read_addr_A_s1_d;
    logic [ADDR_WIDTH-1:0]      read_addr_B_s1_q, read_addr_B_s1_d;
    logic [ADDR_WIDTH-1:0]      write_addr_D_s1_q, write_addr_D_s1_d;

    // Stage 2 registers
    logic                        io_ready_q, io_ready_d;
    logic [READ_PORT_COUNT-1:0]  a_rden_q, a_rden_d;
    logic [READ_PORT_COUNT-1:0]  b_rden_q, b_rden_d;
    logic [WRITE_PORT_COUNT-1:0] d_wren_q, d_wren_d;
    logic [THREAD_ID_WIDTH-1:0]  thread_out_q, thread_out_d;
    logic [COUNT_WIDTH-1:0]      stall_count_q, stall_count_d;
    logic                        stall_saturated_q, stall_saturated_d;

    logic                        valid_s1;
    logic                        ready;
    logic                        blocked;
    logic [THREAD_COUNT-1:0]     thread_hit;
    logic [COUNT_WIDTH-1:0]      count_all [THREAD_COUNT];
    logic [COUNT_WIDTH-1:0]      cur_count;
    logic [COUNT_WIDTH-1:0]      count_inc;

    always_comb begin
        enable_s1_d       = enable;
        thread_id_s1_d    = thread_id;
        read_addr_A_s1_d  = read_addr_A;
        read_addr_B_s1_d  = read_addr_B;
        write_addr_D_s1_d = write_addr_D;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enable_s1_q       <= 1'b0;
            thread_id_s1_q    <= '0;
            read_addr_A_s1_q  <= '0;
            read_addr_B_s1_q  <= '0;
            write_addr_D_s1_q <= '0;
        end else begin
            enable_s1_q       <= enable_s1_d;
            thread_id_s1_q    <= thread_id_s1_d;
            read_addr_A_s1_q  <= read_addr_A_s1_d;
            read_addr_B_s1_q  <= read_addr_B_s1_d;
            write_addr_D_s1_q <= write_addr_D_s1_d;
        end
    end

    // An out-of-range thread id behaves exactly like an idle slot.
    assign valid_s1 = enable_s1_q && (int'(thread_id_s1_q) < THREAD_COUNT);
    assign ready    = valid_s1 & A_EF_masked & B_EF_masked & ~D_EF_masked;
    assign blocked  = valid_s1 & ~ready;

    for (genvar gi = 0; gi < THREAD_COUNT; gi++) begin : g_thread
        logic [COUNT_WIDTH-1:0] count_q, count_d;

        assign thread_hit[gi] = valid_s1 && (int'(thread_id_s1_q) == gi);
        assign count_all[gi]  = count_q;

        always_comb begin
            count_d = count_q;
            if (thread_hit[gi]) begin
                count_d = ready ? '0 : count_inc;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end
    end

    always_comb begin
        cur_count = '0;
        for (int i = 0; i < THREAD_COUNT; i++) begin
            if (thread_hit[i]) begin
                cur_count = count_all[i];
            end
        end
        count_inc = (cur_count == COUNT_MAX) ? COUNT_MAX : cur_count + COUNT_WIDTH'(1);
    end

    always_comb begin
        io_ready_d        = ready;
        thread_out_d      = thread_id_s1_q;
        a_rden_d          = '0;
        b_rden_d          = '0;
        d_wren_d          = '0;
        stall_count_d     = '0;
        stall_saturated_d = stall_saturated_q;
        if (ready && A_addr_is_IO) begin
            a_rden_d = read_onehot(read_addr_A_s1_q);
        end
        if (ready && B_addr_is_IO) begin
            b_rden_d = read_onehot(read_addr_B_s1_q);
        end
        if (ready && D_addr_is_IO) begin
            d_wren_d = write_onehot(write_addr_D_s1_q);
        end
        if (blocked) begin
            stall_count_d = count_inc;
            if (count_inc == COUNT_MAX) begin
                stall_saturated_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            io_ready_q        <= 1'b0;
            a_rden_q          <= '0;
            b_rden_q          <= '0;
            d_wren_q          <= '0;
            thread_out_q      <= '0;
            stall_count_q     <= '0;
            stall_saturated_q <= 1'b0;
        end else begin
            io_ready_q        <= io_ready_d;
            a_rden_q          <= a_rden_d;
            b_rden_q          <= b_rden_d;
            d_wren_q          <= d_wren_d;
            thread_out_q      <= thread_out_d;
            stall_count_q     <= stall_count_d;
            stall_saturated_q <= stall_saturated_d;
        end
    end

    assign IO_ready        = io_ready_q;
    assign A_rden          = a_rden_q;
    assign B_rden          = b_rden_q;
    assign D_wren          = d_wren_q;
    assign thread_out      = thread_out_q;
    assign stall_count     = stall_count_q;
    assign stall_saturated = stall_saturated_q;

endmodule

// File: tb/tb_io_ready_predicate.sv
// Bench for io_ready_predicate: table of instructions with hand-derived results, scoreboarded
// through the two-stage pipeline; a COUNT_WIDTH=2 twin shares the stimulus for saturation checks.
module tb_io_ready_predicate;

    localparam int RB = 16;
    localparam int WB = 32;

    typedef struct {
        logic       en;
        logic [2:0] tid;
        logic [9:0] a, b, d;
        logic       aef, aio, bef, bio, def, dio;
    } txn_t;

    typedef struct {
        logic       io;
        logic [7:0] ar, br, dw;
        logic [2:0] tout;
        logic [7:0] sc;
        logic [1:0] c2;
        logic       sat;
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] thread_id;
    logic [9:0] read_addr_A, read_addr_B, write_addr_D;
    logic       A_EF_masked, A_addr_is_IO, B_EF_masked, B_addr_is_IO, D_EF_masked, D_addr_is_IO;

    logic       io8, sat8, io2, sat2;
    logic [7:0] ar8, br8, dw8, sc8, ar2, br2, dw2;
    logic [2:0] tout8, tout2;
    logic [1:0] sc2;

    always #5 clk = ~clk;

    io_ready_predicate #(
        .READ_PORT_BASE_ADDR (RB),
        .WRITE_PORT_BASE_ADDR(WB)
    ) dut8 (
        .clock(clk), .reset(rst), .enable(enable), .thread_id(thread_id),
        .read_addr_A(read_addr_A), .read_addr_B(read_addr_B), .write_addr_D(write_addr_D),
        .A_EF_masked(A_EF_masked), .A_addr_is_IO(A_addr_is_IO),
        .B_EF_masked(B_EF_masked), .B_addr_is_IO(B_addr_is_IO),
        .D_EF_masked(D_EF_masked), .D_addr_is_IO(D_addr_is_IO),
        .IO_ready(io8), .A_rden(ar8), .B_rden(br8), .D_wren(dw8),
        .thread_out(tout8), .stall_count(sc8), .stall_saturated(sat8)
    );

    io_ready_predicate #(
        .READ_PORT_BASE_ADDR (RB),
        .WRITE_PORT_BASE_ADDR(WB),
        .COUNT_WIDTH         (2)
    ) dut2 (
        .clock(clk), .reset(rst), .enable(enable), .thread_id(thread_id),
        .read_addr_A(read_addr_A), .read_addr_B(read_addr_B), .write_addr_D(write_addr_D),
        .A_EF_masked(A_EF_masked), .A_addr_is_IO(A_addr_is_IO),
        .B_EF_masked(B_EF_masked), .B_addr_is_IO(B_addr_is_IO),
        .D_EF_masked(D_EF_masked), .D_addr_is_IO(D_addr_is_IO),
        .IO_ready(io2), .A_rden(ar2), .B_rden(br2), .D_wren(dw2),
        .thread_out(tout2), .stall_count(sc2), .stall_saturated(sat2)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn    = 0;
    vec_t vecs[$];
    exp_t sb[$];
    txn_t prev_t;
    exp_t prev_e;

    function automatic txn_t tx(input logic en, input int tid, input int a, input int b, input int d,
                                input logic aef, input logic aio, input logic bef, input logic bio,
                                input logic def, input logic dio);
        txn_t t;
        t.en = en; t.tid = 3'(tid); t.a = 10'(a); t.b = 10'(b); t.d = 10'(d);
        t.aef = aef; t.aio = aio; t.bef = bef; t.bio = bio; t.def = def; t.dio = dio;
        return t;
    endfunction

    function automatic exp_t ex(input logic io, input int ar, input int br, input int dw,
                                input int tout, input int sc, input int c2, input logic sat);
        exp_t e;
        e.io = io; e.ar = 8'(ar); e.br = 8'(br); e.dw = 8'(dw);
        e.tout = 3'(tout); e.sc = 8'(sc); e.c2 = 2'(c2); e.sat = sat;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("txn %0d: io_ready=%0b A_rden=%02h B_rden=%02h D_wren=%02h thread=%0d stall=%0d stall2=%0d sat2=%0b",
                     n_txn, io8, ar8, br8, dw8, tout8, sc8, sc2, sat2);
            n_txn++;
            chk("io_ready", 32'(io8), 32'(e.io));
            chk("A_rden", 32'(ar8), 32'(e.ar));
            chk("B_rden", 32'(br8), 32'(e.br));
            chk("D_wren", 32'(dw8), 32'(e.dw));
            chk("thread_out", 32'(tout8), 32'(e.tout));
            chk("stall_count", 32'(sc8), 32'(e.sc));
            chk("stall_count_w2", 32'(sc2), 32'(e.c2));
            chk("stall_saturated_w2", 32'(sat2), 32'(e.sat));
            chk("stall_saturated_w8", 32'(sat8), 32'(0));
        end
    endtask

    // Cycle-0 fields come from the new instruction, cycle-1 check-unit fields from the previous one.
    task automatic drive(input txn_t c0, input txn_t c1);
        enable       = c0.en;
        thread_id    = c0.tid;
        read_addr_A  = c0.a;
        read_addr_B  = c0.b;
        write_addr_D = c0.d;
        A_EF_masked  = c1.aef;
        A_addr_is_IO = c1.aio;
        B_EF_masked  = c1.bef;
        B_addr_is_IO = c1.bio;
        D_EF_masked  = c1.def;
        D_addr_is_IO = c1.dio;
    endtask

    task automatic step(input txn_t t, input exp_t e);
        @(negedge clk);
        compare_pop();
        drive(t, prev_t);
        sb.push_back(prev_e);
        prev_t = t;
        prev_e = e;
    endtask

    task automatic flush(input logic sat);
        step(tx(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, sat));
        step(tx(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, sat));
        @(negedge clk);
        compare_pop();
    endtask

    initial begin
        txn_t idle;
        idle = tx(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Memory-only, then A/D on ports 5 and 2 (thread 3)
        vecs.push_back('{tx(1, 3, 100, 200, 300, 1, 0, 1, 0, 0, 0), ex(1, 0, 0, 0, 3, 0, 0, 0)});
        vecs.push_back('{tx(1, 3, RB+5, 200, WB+2, 1, 1, 1, 0, 0, 1), ex(1, 'h20, 0, 'h04, 3, 0, 0, 0)});
        // Thread 0 blocked on B five times: narrow counter saturates on the third
        for (int k = 0; k < 5; k++)
            vecs.push_back('{tx(1, 0, 100, RB+7, 300, 1, 0, 0, 1, 0, 0),
                             ex(0, 0, 0, 0, 0, k+1, (k < 2) ? k+1 : 3, (k >= 2))});
        // Thread 1 blocked on A three times, then released
        for (int k = 0; k < 3; k++)
            vecs.push_back('{tx(1, 1, RB+5, 200, WB+2, 0, 1, 1, 0, 0, 1), ex(0, 0, 0, 0, 1, k+1, k+1, 1)});
        vecs.push_back('{tx(1, 1, RB+5, 200, WB+2, 1, 1, 1, 0, 0, 1), ex(1, 'h20, 0, 'h04, 1, 0, 0, 1)});
        // Threads 0..7 interleaved, only thread 4 blocked by D full
        for (int t = 0; t < 8; t++) begin
            if (t == 4)
                vecs.push_back('{tx(1, 4, 100, 200, WB+6, 1, 0, 1, 0, 1, 1), ex(0, 0, 0, 0, 4, 1, 1, 1)});
            else
                vecs.push_back('{tx(1, t, 100, 200, 300, 1, 0, 1, 0, 0, 0), ex(1, 0, 0, 0, t, 0, 0, 1)});
        end
        for (int k = 0; k < 2; k++)
            vecs.push_back('{tx(1, 4, 100, 200, WB+6, 1, 0, 1, 0, 1, 1), ex(0, 0, 0, 0, 4, k+2, k+2, 1)});
        // A and B on the same port; disabled slot; offset wrap; D full blocks A strobe
        vecs.push_back('{tx(1, 2, RB+3, RB+3, 300, 1, 1, 1, 1, 0, 0), ex(1, 'h08, 'h08, 0, 2, 0, 0, 1)});
        vecs.push_back('{tx(0, 5, RB+1, RB+1, WB+1, 1, 1, 1, 1, 0, 1), ex(0, 0, 0, 0, 5, 0, 0, 1)});
        vecs.push_back('{tx(1, 6, RB+13, 200, WB+9, 1, 1, 1, 0, 0, 1), ex(1, 'h20, 0, 'h02, 6, 0, 0, 1)});
        vecs.push_back('{tx(1, 7, RB+2, 200, WB+4, 1, 1, 1, 0, 1, 1), ex(0, 0, 0, 0, 7, 1, 1, 1)});

        rst = 1'b1;
        drive(idle, idle);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        prev_t = idle;
        prev_e = ex(0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) step(vecs[i].t, vecs[i].e);
        flush(1'b1);

        // Reset while an I/O instruction sits in stage 1
        @(negedge clk);
        drive(tx(1, 5, RB+1, 100, WB+3, 0, 0, 0, 0, 0, 0), idle);
        @(negedge clk);
        rst = 1'b1;
        drive(idle, tx(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rst_io_ready", 32'(io8), 32'(0));
            chk("rst_A_rden", 32'(ar8), 32'(0));
            chk("rst_D_wren", 32'(dw8), 32'(0));
            chk("rst_stall_count", 32'(sc8), 32'(0));
            chk("rst_saturated_w2", 32'(sat2), 32'(0));
            @(negedge clk);
        end
        drive(idle, idle);
        prev_t = idle;
        prev_e = ex(0, 0, 0, 0, 0, 0, 0, 0);
        // Thread 4 had count 3 before reset; restarting at 1 shows counters were cleared
        step(tx(1, 4, 100, 200, WB+6, 1, 0, 1, 0, 1, 1), ex(0, 0, 0, 0, 4, 1, 1, 0));
        flush(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
